mem_port_arbiter: RTL and testbench

//  Shares the single unified memory port between two requesters: the multicycle

---
 rtl/mem_port_arbiter_if.sv | 16 +
 rtl/mem_port_arbiter.sv | 117 +++++++++++
 tb/tb_mem_port_arbiter.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Requester-side handshake bundle for mem_port_arbiter: one instance per requester.
// master = requester (core or loader), slave = arbiter.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req;
  logic          we;
  logic [AW-1:0] adr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          ready;

  modport master (output req, we, adr, wdata, input rdata, ready);
  modport slave  (input req, we, adr, wdata, output rdata, ready);
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the core (c_port) and a loader (d_port); one transaction in flight.
// Define MEM_ARB_CORE_PRIO_EN for fixed core priority instead of round-robin.
module mem_port_arbiter #(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  mem_port_arbiter_if.slave     c_port,
  mem_port_arbiter_if.slave     d_port,
  output logic                  m_we,
  output logic [AW-1:0]         m_adr,
  output logic [DW-1:0]         m_wdata,
  input  logic [DW-1:0]         m_rdata
);

  if (RD_LAT < 1 || RD_LAT > 7) begin : g_bad_rd_lat
    $error("mem_port_arbiter: RD_LAT must be within 1..7");
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  localparam logic [2:0] LP_WAIT_INIT = 3'(RD_LAT - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_owner_d;
  logic          r_we;
  logic [AW-1:0] r_adr;
  logic [DW-1:0] r_wdata;
  logic [2:0]    r_wait_cnt;
  logic [DW-1:0] r_c_rdata;
  logic [DW-1:0] r_d_rdata;
  logic          w_grant;
  logic          w_grant_d;

`ifdef MEM_ARB_CORE_PRIO_EN
  always_comb begin
    w_grant   = c_port.req | d_port.req;
    w_grant_d = ~c_port.req;
  end
`else
  // r_last_d=1 means the loader had the last grant, so the core wins the next tie.
  logic r_last_d;

  always_comb begin
    w_grant   = c_port.req | d_port.req;
    w_grant_d = d_port.req & (~c_port.req | ~r_last_d);
  end
`endif

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_grant) w_state_nxt = S_ISSUE;
      S_ISSUE: w_state_nxt = r_we ? S_DONE : S_WAIT;
      S_WAIT:  if (r_wait_cnt == 3'd0) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_owner_d  <= 1'b0;
      r_we       <= 1'b0;
      r_adr      <= '0;
      r_wdata    <= '0;
      r_wait_cnt <= 3'd0;
      r_c_rdata  <= '0;
      r_d_rdata  <= '0;
`ifndef MEM_ARB_CORE_PRIO_EN
      r_last_d   <= 1'b1;
`endif
    end else begin
      if (r_state == S_IDLE && w_grant) begin
        r_owner_d <= w_grant_d;
        r_we      <= w_grant_d ? d_port.we    : c_port.we;
        r_adr     <= w_grant_d ? d_port.adr   : c_port.adr;
        r_wdata   <= w_grant_d ? d_port.wdata : c_port.wdata;
`ifndef MEM_ARB_CORE_PRIO_EN
        r_last_d  <= w_grant_d;
`endif
      end

      if (r_state == S_ISSUE) begin
        r_wait_cnt <= LP_WAIT_INIT;
      end else if (r_state == S_WAIT) begin
        if (r_wait_cnt != 3'd0) begin
          r_wait_cnt <= r_wait_cnt - 3'd1;
        end else if (r_owner_d) begin
          r_d_rdata <= m_rdata;
        end else begin
          r_c_rdata <= m_rdata;
        end
      end
    end
  end

  // Decoded from the state register so reset clears m_we and ready without waiting for an edge.
  assign m_we         = (r_state == S_ISSUE) && r_we;
  assign m_adr        = r_adr;
  assign m_wdata      = r_wdata;
  assign c_port.ready = (r_state == S_DONE) && !r_owner_d;
  assign d_port.ready = (r_state == S_DONE) &&  r_owner_d;
  assign c_port.rdata = r_c_rdata;
  assign d_port.rdata = r_d_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: instance 0 uses RD_LAT=1, instance 1 uses RD_LAT=3.
// Stimulus pushes hand-computed issue/ready expectations; per-instance monitors pop and compare.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  typedef struct {
    int          dut;
    int          cyc;
    logic [1:0]  rdy;   // {c_ready, d_ready}
    logic [31:0] c_rd;
    logic [31:0] d_rd;
  } rsp_t;

  typedef struct {
    int          dut;
    int          cyc;
    logic        we;
    logic [31:0] adr;
    logic [31:0] wdata;
  } iss_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  rsp_t rsp_q[$];
  iss_t iss_q[$];

  // Requester-side drive, indexed [instance][port], port 0 = core, 1 = loader.
  logic        req_a   [2][2];
  logic        we_a    [2][2];
  logic [31:0] adr_a   [2][2];
  logic [31:0] wdata_a [2][2];
  wire  [31:0] rdata_a [2][2];
  wire         rdy_a   [2][2];
  wire         m_we_a    [2];
  wire  [31:0] m_adr_a   [2];
  wire  [31:0] m_wdata_a [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic exp_iss(input int dut, input int c, input logic we, input logic [31:0] adr,
                         input logic [31:0] wd);
    iss_t s;
    s.dut = dut; s.cyc = c; s.we = we; s.adr = adr; s.wdata = wd;
    iss_q.push_back(s);
  endtask

  task automatic exp_rsp(input int dut, input int c, input logic [1:0] rdy, input logic [31:0] crd,
                         input logic [31:0] drd);
    rsp_t r;
    r.dut = dut; r.cyc = c; r.rdy = rdy; r.c_rd = crd; r.d_rd = drd;
    rsp_q.push_back(r);
  endtask

  // Called at a negedge; returns at the negedge where ready was seen, with req dropped.
  task automatic do_txn(input int dut, input int port, input logic w, input logic [31:0] a,
                        input logic [31:0] wd);
    int n;
    we_a[dut][port]    = w;
    adr_a[dut][port]   = a;
    wdata_a[dut][port] = wd;
    req_a[dut][port]   = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rdy_a[dut][port] && n < 40);
    check("txn_ready_seen", 64'(rdy_a[dut][port]), 64'(1));
    req_a[dut][port] = 1'b0;
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int RL = (g == 0) ? 1 : 3;

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) c_if ();
    mem_port_arbiter_if #(.AW(AW), .DW(DW)) d_if ();

    logic [31:0] m_rdata;
    logic [31:0] mem [0:1023];
    int          chg_cyc = 0;
    logic [31:0] last_adr = '0;

    assign c_if.req   = req_a[g][0];
    assign c_if.we    = we_a[g][0];
    assign c_if.adr   = adr_a[g][0];
    assign c_if.wdata = wdata_a[g][0];
    assign d_if.req   = req_a[g][1];
    assign d_if.we    = we_a[g][1];
    assign d_if.adr   = adr_a[g][1];
    assign d_if.wdata = wdata_a[g][1];
    assign rdata_a[g][0] = c_if.rdata;
    assign rdata_a[g][1] = d_if.rdata;
    assign rdy_a[g][0]   = c_if.ready;
    assign rdy_a[g][1]   = d_if.ready;

    mem_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RL)) u_dut (
      .clk     (clk),
      .reset   (rst),
      .c_port  (c_if),
      .d_port  (d_if),
      .m_we    (m_we_a[g]),
      .m_adr   (m_adr_a[g]),
      .m_wdata (m_wdata_a[g]),
      .m_rdata (m_rdata)
    );

    initial begin
      m_rdata = '0;
      for (int i = 0; i < 1024; i++) mem[i] = 32'hA500_0000 | (32'(g) << 16) | 32'(i);
      if (g == 0) begin
        mem[16] = 32'hDEAD_BEEF;
      end else begin
        mem[32] = 32'h1357_9BDF;
        mem[48] = 32'h2468_ACE0;
      end
    end

    // Memory model: data is valid only exactly RL cycles after m_adr changed, garbage otherwise.
    always @(negedge clk) begin
      rsp_t r;
      iss_t s;
      if (m_adr_a[g] !== last_adr) begin
        chg_cyc  = cyc;
        last_adr = m_adr_a[g];
      end
      if (!rst && m_we_a[g]) mem[m_adr_a[g][11:2]] = m_wdata_a[g];
      m_rdata = (cyc - chg_cyc == RL) ? mem[m_adr_a[g][11:2]] : (32'hBAD0_0000 ^ 32'(cyc));

      if (!rst) begin
        if (iss_q.size() > 0 && iss_q[0].dut == g && iss_q[0].cyc <= cyc) begin
          s = iss_q.pop_front();
          check("issue_cycle", 64'(cyc), 64'(s.cyc));
          check("issue_m_we", 64'(m_we_a[g]), 64'(s.we));
          check("issue_m_adr", 64'(m_adr_a[g]), 64'(s.adr));
          if (s.we) check("issue_m_wdata", 64'(m_wdata_a[g]), 64'(s.wdata));
        end else if (m_we_a[g]) begin
          check("stray_m_we", 64'(m_we_a[g]), 64'(0));
        end

        if (rdy_a[g][0] || rdy_a[g][1]) begin
          if (rsp_q.size() == 0 || rsp_q[0].dut != g) begin
            check("stray_ready", 64'({rdy_a[g][0], rdy_a[g][1]}), 64'(0));
          end else begin
            r = rsp_q.pop_front();
            check("ready_cycle", 64'(cyc), 64'(r.cyc));
            check("ready_port", 64'({rdy_a[g][0], rdy_a[g][1]}), 64'(r.rdy));
            check("c_rdata", 64'(rdata_a[g][0]), 64'(r.c_rd));
            check("d_rdata", 64'(rdata_a[g][1]), 64'(r.d_rd));
          end
        end else if (rsp_q.size() > 0 && rsp_q[0].dut == g && rsp_q[0].cyc < cyc) begin
          r = rsp_q.pop_front();
          check("ready_missing", 64'({rdy_a[g][0], rdy_a[g][1]}), 64'(r.rdy));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0;
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) begin
        req_a[d][p] = 1'b0; we_a[d][p] = 1'b0; adr_a[d][p] = '0; wdata_a[d][p] = '0;
      end
    end

    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst_m_we",    64'(m_we_a[d]),     64'(0));
      check("rst_m_adr",   64'(m_adr_a[d]),    64'(0));
      check("rst_m_wdata", 64'(m_wdata_a[d]),  64'(0));
      check("rst_c_ready", 64'(rdy_a[d][0]),   64'(0));
      check("rst_d_ready", 64'(rdy_a[d][1]),   64'(0));
      check("rst_c_rdata", 64'(rdata_a[d][0]), 64'(0));
      check("rst_d_rdata", 64'(rdata_a[d][1]), 64'(0));
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Core read alone, RD_LAT=1.
    t0 = cyc;
    exp_iss(0, t0 + 1, 1'b0, 32'h40, 32'h0);
    exp_rsp(0, t0 + 3, 2'b10, 32'hDEAD_BEEF, 32'h0);
    do_txn(0, 0, 1'b0, 32'h40, 32'h0);
    @(negedge clk);

    // Loader write.
    t0 = cyc;
    exp_iss(0, t0 + 1, 1'b1, 32'h100, 32'h1234);
    exp_rsp(0, t0 + 2, 2'b01, 32'hDEAD_BEEF, 32'h0);
    do_txn(0, 1, 1'b1, 32'h100, 32'h1234);
    @(negedge clk);

    // Both requesters raised together and kept busy.
    t0 = cyc;
`ifdef MEM_ARB_CORE_PRIO_EN
    for (int k = 0; k < 4; k++) begin
      exp_iss(0, t0 + 1 + 3 * k, 1'b1, 32'h200 + 32'(16 * k), 32'hC000_0000 + 32'(k));
      exp_rsp(0, t0 + 2 + 3 * k, 2'b10, 32'hDEAD_BEEF, 32'h0);
    end
    exp_iss(0, t0 + 13, 1'b1, 32'h300, 32'hD000_0000);
    exp_rsp(0, t0 + 14, 2'b01, 32'hDEAD_BEEF, 32'h0);
    fork
      begin
        for (int k = 0; k < 4; k++) do_txn(0, 0, 1'b1, 32'h200 + 32'(16 * k), 32'hC000_0000 + 32'(k));
      end
      do_txn(0, 1, 1'b1, 32'h300, 32'hD000_0000);
    join
`else
    for (int k = 0; k < 2; k++) begin
      exp_iss(0, t0 + 1 + 6 * k, 1'b1, 32'h200 + 32'(16 * k), 32'hC000_0000 + 32'(k));
      exp_iss(0, t0 + 4 + 6 * k, 1'b1, 32'h300 + 32'(16 * k), 32'hD000_0000 + 32'(k));
      exp_rsp(0, t0 + 2 + 6 * k, 2'b10, 32'hDEAD_BEEF, 32'h0);
      exp_rsp(0, t0 + 5 + 6 * k, 2'b01, 32'hDEAD_BEEF, 32'h0);
    end
    fork
      begin
        for (int k = 0; k < 2; k++) do_txn(0, 0, 1'b1, 32'h200 + 32'(16 * k), 32'hC000_0000 + 32'(k));
      end
      begin
        for (int k = 0; k < 2; k++) do_txn(0, 1, 1'b1, 32'h300 + 32'(16 * k), 32'hD000_0000 + 32'(k));
      end
    join
`endif
    @(negedge clk);

    // RD_LAT=3: loader read, then a core read presented right after d_ready.
    t0 = cyc;
    exp_iss(1, t0 + 1, 1'b0, 32'h80, 32'h0);
    exp_rsp(1, t0 + 5, 2'b01, 32'h0, 32'h1357_9BDF);
    exp_iss(1, t0 + 7, 1'b0, 32'hC0, 32'h0);
    exp_rsp(1, t0 + 11, 2'b10, 32'h2468_ACE0, 32'h1357_9BDF);
    do_txn(1, 1, 1'b0, 32'h80, 32'h0);
    do_txn(1, 0, 1'b0, 32'hC0, 32'h0);
    @(negedge clk);

    // Reset during the ISSUE cycle of a core write.
    we_a[0][0] = 1'b1; adr_a[0][0] = 32'h400; wdata_a[0][0] = 32'h5555; req_a[0][0] = 1'b1;
    @(posedge clk);
    #2;
    check("t5_m_we_in_issue", 64'(m_we_a[0]), 64'(1));
    rst = 1'b1;
    #1;
    check("t5_m_we_async", 64'(m_we_a[0]),     64'(0));
    check("t5_m_adr",      64'(m_adr_a[0]),    64'(0));
    check("t5_m_wdata",    64'(m_wdata_a[0]),  64'(0));
    check("t5_c_rdata",    64'(rdata_a[0][0]), 64'(0));
    check("t5_c_ready",    64'(rdy_a[0][0]),   64'(0));
    req_a[0][0] = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    t0 = cyc;
    exp_iss(0, t0 + 1, 1'b0, 32'h40, 32'h0);
    exp_rsp(0, t0 + 3, 2'b10, 32'hDEAD_BEEF, 32'h0);
    do_txn(0, 0, 1'b0, 32'h40, 32'h0);

    repeat (4) @(negedge clk);
    check("rsp_queue_drained", 64'(rsp_q.size()), 64'(0));
    check("iss_queue_drained", 64'(iss_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
